// File: rtl/viewport_pkg.sv
// Shared types and constants for the viewport mapping stage.
// NDC fixed point is Q2.16 in 19 signed bits; depth is 16-bit unsigned.
package viewport_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONV_X,
        CONV_Y,
        CONV_Z,
        SCALE,
        CLAMP,
        DONE
    } state_t;

    localparam int Q_ONE       = 65536;
    localparam int Q_SAT       = 131071;
    localparam int FP_EXP_BIAS = 127;
    localparam int DEPTH_MAX   = 65535;

endpackage

// File: rtl/viewport_transform_if.sv
// Start/done level handshake plus vertex in and screen coordinates out.
// master drives a vertex, slave is the viewport stage.
interface viewport_transform_if;

    logic        start;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [11:0] px;
    logic [11:0] py;
    logic [15:0] depth;
    logic        clipped;
    logic        busy;
    logic        done;

    modport master (
        output start, x, y, z,
        input  px, py, depth, clipped, busy, done
    );

    modport slave (
        input  start, x, y, z,
        output px, py, depth, clipped, busy, done
    );

endinterface

// File: rtl/viewport_transform_fp_to_fixed.sv
// Combinational fp32 to signed Q2.16 converter, truncating toward zero.
// oor flags |v| > 1.0 or Inf/NaN; exactly +-1.0 is in range.
module fp_to_fixed (
    input  logic [31:0]        v,
    output logic signed [18:0] q,
    output logic               oor
);
    import viewport_pkg::*;

    logic        sign;
    logic [7:0]  e;
    logic [22:0] m;
    logic        nan;
    logic [7:0]  sh;
    logic [23:0] mag;

    always_comb begin
        sign = v[31];
        e    = v[30:23];
        m    = v[22:0];
        nan  = (e == 8'hFF) && (m != '0);
        // 134 - e: a biased exponent of 127 lands the hidden one on bit 16
        sh   = 8'(FP_EXP_BIAS + 7) - e;
        mag  = {1'b1, m} >> sh;
        q    = '0;
        oor  = 1'b0;
        if (e == 8'd0) begin
            q = '0;
        end else if (e > 8'(FP_EXP_BIAS)) begin
            q   = (sign && !nan) ? -19'(Q_SAT) : 19'(Q_SAT);
            oor = 1'b1;
        end else begin
            q   = sign ? -19'(mag) : 19'(mag);
            oor = (e == 8'(FP_EXP_BIAS)) && (m != '0);
        end
    end

endmodule

// File: rtl/viewport_transform.sv
// NDC vertex to screen pixel/depth mapping, five cycles per vertex.
// One shared float converter walks x, y, z before scale and clamp.
module viewport_transform #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic                 clk,
    input  logic                 areset_n,
    viewport_transform_if.slave  bus
);
    import viewport_pkg::*;

    localparam logic signed [35:0] Q1    = 36'(Q_ONE);
    localparam logic signed [35:0] W36   = 36'(WIDTH);
    localparam logic signed [35:0] H36   = 36'(HEIGHT);
    localparam logic signed [35:0] D36   = 36'(DEPTH_MAX);
    localparam logic signed [35:0] LIM_X = 36'(WIDTH - 1);
    localparam logic signed [35:0] LIM_Y = 36'(HEIGHT - 1);

    state_t state, nxt;

    logic [31:0]        xin, yin, zin;
    logic [31:0]        cin;
    logic signed [18:0] cq;
    logic               co;
    logic signed [18:0] xq, yq, zq;
    logic               fx, fy, fz;
    logic signed [35:0] sx, sy, sz;
    logic signed [35:0] rx, ry, rz;
    logic [11:0]        px_n, py_n;
    logic [15:0]        dz_n;
    logic               accept;

    assign accept = bus.start && (state == IDLE || state == DONE);

    fp_to_fixed u_conv (
        .v   (cin),
        .q   (cq),
        .oor (co)
    );

    always_comb begin
        case (state)
            CONV_Y:  cin = yin;
            CONV_Z:  cin = zin;
            default: cin = xin;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) state <= IDLE;
        else           state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = CONV_X;
            CONV_X:  nxt = CONV_Y;
            CONV_Y:  nxt = CONV_Z;
            CONV_Z:  nxt = SCALE;
            SCALE:   nxt = CLAMP;
            CLAMP:   nxt = DONE;
            DONE:    if (accept) nxt = CONV_X;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == CONV_X) || (state == CONV_Y) ||
                   (state == CONV_Z) || (state == SCALE) ||
                   (state == CLAMP);
        bus.done = (state == DONE);
    end

    // Arithmetic shift keeps negatives negative so the sign bit drives the low clamp
    always_comb begin
        rx   = sx >>> 17;
        ry   = sy >>> 17;
        rz   = sz >>> 17;
        px_n = rx[35] ? '0 : (rx > LIM_X) ? LIM_X[11:0] : rx[11:0];
        py_n = ry[35] ? '0 : (ry > LIM_Y) ? LIM_Y[11:0] : ry[11:0];
        dz_n = rz[35] ? '0 : (rz > D36)   ? D36[15:0]   : rz[15:0];
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            xin         <= '0;
            yin         <= '0;
            zin         <= '0;
            xq          <= '0;
            yq          <= '0;
            zq          <= '0;
            fx          <= 1'b0;
            fy          <= 1'b0;
            fz          <= 1'b0;
            sx          <= '0;
            sy          <= '0;
            sz          <= '0;
            bus.px      <= '0;
            bus.py      <= '0;
            bus.depth   <= '0;
            bus.clipped <= 1'b0;
        end else begin
            if (accept) begin
                xin <= bus.x;
                yin <= bus.y;
                zin <= bus.z;
            end
            case (state)
                CONV_X: begin
                    xq <= cq;
                    fx <= co;
                end
                CONV_Y: begin
                    yq <= cq;
                    fy <= co;
                end
                CONV_Z: begin
                    zq <= cq;
                    fz <= co;
                end
                SCALE: begin
                    sx <= (36'(xq) + Q1) * W36;
                    sy <= (Q1 - 36'(yq)) * H36;
                    sz <= (36'(zq) + Q1) * D36;
                end
                CLAMP: begin
                    bus.px      <= px_n;
                    bus.py      <= py_n;
                    bus.depth   <= dz_n;
                    bus.clipped <= fx | fy | fz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_viewport_transform.sv
// Scoreboard bench for viewport_transform at 640x480.
// Driver queues expected results; a monitor checks each rising done.
module tb_viewport_transform;

    typedef struct packed {
        logic [11:0] px;
        logic [11:0] py;
        logic [15:0] depth;
        logic        clipped;
    } exp_t;

    logic clk = 1'b0;
    logic areset_n;
    logic done_q = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    viewport_transform_if bus ();

    viewport_transform #(
        .WIDTH  (640),
        .HEIGHT (480)
    ) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    localparam exp_t E_ORG  = '{12'd320, 12'd240, 16'd32767, 1'b0};
    localparam exp_t E_NEG  = '{12'd0,   12'd0,   16'd0,     1'b0};
    localparam exp_t E_POS  = '{12'd639, 12'd479, 16'd65535, 1'b0};
    localparam exp_t E_OOR  = '{12'd639, 12'd120, 16'd32767, 1'b1};
    localparam exp_t E_NAN  = '{12'd639, 12'd240, 16'd32767, 1'b1};

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done && !done_q) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no result");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("px", 32'(bus.px), 32'(e.px));
                chk("py", 32'(bus.py), 32'(e.py));
                chk("depth", 32'(bus.depth), 32'(e.depth));
                chk("clipped", 32'(bus.clipped), 32'(e.clipped));
            end
        end
        done_q <= bus.done;
    end

    task automatic set_vec(logic [31:0] vx, logic [31:0] vy, logic [31:0] vz);
        bus.x = vx;
        bus.y = vy;
        bus.z = vz;
    endtask

    task automatic send(logic [31:0] vx, logic [31:0] vy, logic [31:0] vz, exp_t e);
        @(negedge clk);
        bus.start = 1'b1;
        set_vec(vx, vy, vz);
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(string name, int want_busy);
        int n;
        int k;
        n = bus.busy ? 1 : 0;
        k = 0;
        while (!bus.done && k < 20) begin
            @(negedge clk);
            k++;
            if (bus.busy) n++;
        end
        chk({name, "_done"}, 32'(bus.done), 32'd1);
        chk({name, "_busy_cycles"}, 32'(n), 32'(want_busy));
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_px"}, 32'(bus.px), 32'd0);
        chk({tag, "_py"}, 32'(bus.py), 32'd0);
        chk({tag, "_depth"}, 32'(bus.depth), 32'd0);
        chk({tag, "_clipped"}, 32'(bus.clipped), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        logic [31:0] mask;
        areset_n  = 1'b0;
        bus.start = 1'b0;
        set_vec('0, '0, '0);
        #2;
        chk_zero("reset");
        @(negedge clk);
        areset_n = 1'b1;

        send(32'h0, 32'h0, 32'h0, E_ORG);
        wait_done("origin", 5);
        send(32'hBF800000, 32'h3F800000, 32'hBF800000, E_NEG);
        wait_done("corner_neg", 5);
        send(32'h3F800000, 32'hBF800000, 32'h3F800000, E_POS);
        wait_done("corner_pos", 5);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("hold_done", 32'(bus.done), 32'd1);
            chk("hold_px", 32'(bus.px), 32'd639);
            chk("hold_depth", 32'(bus.depth), 32'd65535);
        end

        send(32'h3FC00000, 32'h3F000000, 32'h0, E_OOR);
        wait_done("out_of_range", 5);
        send(32'h7FC00000, 32'h0, 32'h0, E_NAN);
        wait_done("nan", 5);

        send(32'h3FC00000, 32'h3F000000, 32'h0, E_OOR);
        @(negedge clk);
        bus.start = 1'b1;
        set_vec(32'h0, 32'h0, 32'h0);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ignored_start", 3);

        @(negedge clk);
        bus.start = 1'b1;
        set_vec(32'h0, 32'h0, 32'h0);
        sb.push_back(E_ORG);
        sb.push_back(E_NEG);
        sb.push_back(E_POS);
        mask = '0;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            mask[i] = bus.done;
            if (i == 1) set_vec(32'hBF800000, 32'h3F800000, 32'hBF800000);
            if (i == 7) set_vec(32'h3F800000, 32'hBF800000, 32'h3F800000);
            if (i == 13) bus.start = 1'b0;
        end
        chk("stream_done_pattern", mask, 32'h0000_1040);
        wait_done("stream_last", 5);

        send(32'h3FC00000, 32'h3F000000, 32'h0, E_OOR);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_busy", 32'(bus.busy), 32'd1);
        areset_n = 1'b0;
        #1;
        chk_zero("mid_reset");
        sb.delete();
        @(negedge clk);
        areset_n = 1'b1;
        send(32'h0, 32'h0, 32'h0, E_ORG);
        wait_done("after_reset", 5);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
